// File: rtl/fnd_timer_display.sv
// fnd_timer_display: 4-digit common-anode 7-segment driver for the Timer.
// Scans digits, selects HH.MM / SS.cc page, blinks the edited field and
// flashes the whole display for ALARM_TOGGLES blink phases after iEnd rises.
// Optional macro: FND_LEADING_ZERO_BLANK_EN blanks a leading hour-tens zero.
module fnd_timer_display #(
    parameter int SYS_CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ       = 4_000,
    parameter int BLINK_HZ      = 2,
    parameter int ALARM_TOGGLES = 20
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [1:0] iSet,
    input  logic [6:0] imSec,
    input  logic [5:0] iSec,
    input  logic [5:0] iMin,
    input  logic [4:0] iHour,
    input  logic       iEnd,
    input  logic       iPage,
    output logic [3:0] oFnd_Com,
    output logic [7:0] oFnd_Data
);

    localparam int SCAN_DIV  = SYS_CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = SYS_CLK_HZ / (2 * BLINK_HZ);
    localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int ALARM_W   = $clog2(ALARM_TOGGLES + 1);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [ALARM_W-1:0] ALARM_LOAD = ALARM_W'(ALARM_TOGGLES);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    logic [SCAN_W-1:0]  scanCnt;
    logic [BLINK_W-1:0] blinkCnt;
    logic [1:0]         digitIdx;
    logic               blinkPhase;
    logic [ALARM_W-1:0] alarmCnt;
    logic               endReg;
    logic               endPrev;

    logic       scanTick;
    logic       phaseTick;
    logic       endRise;
    logic       pageSel;
    logic [6:0] hiVal;
    logic [6:0] loVal;
    logic [6:0] fieldVal;
    logic [6:0] digitVal;
    logic       fieldBlank;
    logic [7:0] segNext;
    logic [3:0] comNext;

    // 7-bit value 0..9 to active-low segment pattern; anything else blank
    function automatic logic [7:0] glyph(input logic [6:0] d);
        case (d)
            7'd0:    glyph = 8'hC0;
            7'd1:    glyph = 8'hF9;
            7'd2:    glyph = 8'hA4;
            7'd3:    glyph = 8'hB0;
            7'd4:    glyph = 8'h99;
            7'd5:    glyph = 8'h92;
            7'd6:    glyph = 8'h82;
            7'd7:    glyph = 8'hF8;
            7'd8:    glyph = 8'h80;
            7'd9:    glyph = 8'h90;
            default: glyph = 8'hFF;
        endcase
    endfunction

    assign scanTick  = (scanCnt == SCAN_LAST);
    assign phaseTick = (blinkCnt == BLINK_LAST);
    assign endRise   = endReg & ~endPrev;

    // Scan divider and digit index; index moves on the edge that ends a scan slot
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            scanCnt  <= '0;
            digitIdx <= 2'd0;
        end else if (scanTick) begin
            scanCnt  <= '0;
            digitIdx <= digitIdx + 2'd1;
        end else begin
            scanCnt  <= scanCnt + 1'b1;
        end
    end

    // Free-running blink phase, independent of the scan
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (phaseTick) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
        end else begin
            blinkCnt   <= blinkCnt + 1'b1;
        end
    end

    // iEnd edge detect and alarm toggle budget; a fresh rise wins over a decrement
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            endReg   <= 1'b0;
            endPrev  <= 1'b0;
            alarmCnt <= '0;
        end else begin
            endReg  <= iEnd;
            endPrev <= endReg;
            if (endRise)
                alarmCnt <= ALARM_LOAD;
            else if (phaseTick && alarmCnt != '0)
                alarmCnt <= alarmCnt - 1'b1;
        end
    end

    // Digit content for the current index, with blink/alarm blanking and dp
    always_comb begin
        case (iSet)
            2'b10, 2'b01: pageSel = 1'b0;
            2'b11:        pageSel = 1'b1;
            default:      pageSel = iPage;
        endcase

        hiVal    = pageSel ? {1'b0, iSec} : {2'b00, iHour};
        loVal    = pageSel ? imSec : {1'b0, iMin};
        fieldVal = digitIdx[1] ? hiVal : loVal;
        digitVal = digitIdx[0] ? (fieldVal / 7'd10) : (fieldVal % 7'd10);

        if (fieldVal > 7'd99)
            segNext = SEG_DASH;
        else
            segNext = glyph(digitVal);

`ifdef FND_LEADING_ZERO_BLANK_EN
        if (!pageSel && digitIdx == 2'd3 && iHour < 5'd10)
            segNext = SEG_BLANK;
`endif

        // hour and sec live on the left pair, min on the right pair
        case (iSet)
            2'b10, 2'b11: fieldBlank = digitIdx[1];
            2'b01:        fieldBlank = ~digitIdx[1];
            default:      fieldBlank = 1'b0;
        endcase

        // alarm and field blink blank on the same phase, so one test covers both
        if (blinkPhase && (fieldBlank || alarmCnt != '0))
            segNext = SEG_BLANK;

        if (digitIdx == 2'd2 && segNext != SEG_BLANK)
            segNext[7] = 1'b0;

        comNext = ~(4'b0001 << digitIdx);
    end

    // Anodes and segments registered together so they switch on the same edge
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oFnd_Com  <= 4'b1111;
            oFnd_Data <= SEG_BLANK;
        end else begin
            oFnd_Com  <= comNext;
            oFnd_Data <= segNext;
        end
    end

endmodule
